fifo_write_arbiter: RTL and testbench
=====================================

# fifo_write_arbiter

Round-robin write-side arbiter that shares one `fifo` write port among NREQ requesters, such as the host command path and internal motion generators. Each grant transfers a whole multi-word burst atomically, so a multi-word command is never interleaved with another requester's words. A burst is granted only when the FIFO's `free_count` can hold all of its words.

## Interface
- NREQ, 4, number of requesters
- DATA_WIDTH, 8, FIFO word width
- ADDRESS_WIDTH, 12, FIFO address width; must match the attached fifo
- LEN_WIDTH, 4, burst length field width; LEN_WIDTH <= ADDRESS_WIDTH

- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NREQ  requester i has a burst pending or in progress
- req_len  in  NREQ*LEN_WIDTH  burst length in words, slice i; 0 means no request
- req_data  in  NREQ*DATA_WIDTH  current word of requester i
- req_ready  out  NREQ  word of requester i is written this cycle
- grant  out  NREQ  one-hot registered burst owner; 0 when idle
- busy  out  1  burst in progress
- fifo_write  out  1  to fifo `write`
- fifo_write_data  out  DATA_WIDTH  to fifo `write_data`
- fifo_full  in  1  from fifo `full`
- fifo_free_count  in  ADDRESS_WIDTH+1  from fifo `free_count`

## Operation
- The block has two states, IDLE and BURST. Registers:
  - owner index
  - last_owner index, reset to NREQ-1, so requester 0 has first priority
  - remaining counter, LEN_WIDTH bits
- **Eligibility:** requester i is eligible when `req_valid[i]` is high and `req_len[i]` is not 0.
- **IDLE:**
  - Candidate = first eligible index scanning last_owner+1, last_owner+2, … with modulo NREQ wrap.
  - If no candidate exists, stay in IDLE.
  - If candidate exists and zero-extended `req_len[c]` <= `fifo_free_count`:
    - owner <= c, remaining <= `req_len[c]`, grant <= one-hot(c), go to BURST.
  - If the candidate does not fit, stay in IDLE with last_owner unchanged; do not skip to a smaller burst. Blocking on the candidate prevents starvation of long bursts.
- **BURST:**
  - wr = `req_valid[owner]` & ~`fifo_full`.
  - fifo_write = wr; `req_ready[owner]` = wr; all other req_ready bits = 0.
  - fifo_write_data = `req_data` slice of owner; all zeros in IDLE.
  - On wr, remaining decrements.
  - On wr with remaining == 1: last_owner <= owner, grant <= 0, go to IDLE.
  - If `req_valid[owner]` is low, stall with no write and grant held. The burst is never abandoned.
  - `req_len` is sampled only at grant; later changes are ignored.
- **Requester protocol:**
  - Hold `req_valid` and the current word until `req_ready` is seen.
  - Present the next word in the cycle after `req_ready`.
  - Drop `req_valid` after the last word unless another burst follows.
- busy = (state == BURST).
- **FIFO space:** concurrent fifo reads only increase free space, so a reserved burst always fits. `fifo_full` gating is kept for safety.

## Timing
- Reset (reset_n low, asynchronous):
  - state IDLE, grant 0, busy 0, remaining 0, last_owner NREQ-1
  - fifo_write, req_ready and fifo_write_data are all 0 while in reset
- Arbitration decision in IDLE cycle t: grant and busy are high from cycle t+1, and the first write can occur in t+1.
- A burst of L words with no stalls takes L BURST cycles plus 1 IDLE cycle: L+1 cycles per burst, back to back.
- `fifo_free_count` is registered in the fifo. A write in the last BURST cycle is already reflected in the next IDLE cycle's comparison.
- fifo_write and req_ready are combinational from registered state, `req_valid[owner]` and `fifo_full`. There is no registered latency between handshake and write.
- reset_n deasserted mid-burst: the burst is dropped and the already-written words stay in the FIFO. Requesters must be reset together with the block.

## Test plan
- **Reset then idle:** reset_n low then high, no requests -> grant=0, busy=0, fifo_write=0 every cycle.
- **Single burst:** req 2, len=3, data A,B,C, free=4096 -> grant=0100 at t+1; fifo_write in t+1..t+3 with A,B,C; req_ready[2] high three cycles; IDLE at t+4.
- **Round-robin:** all 4 requesting len=1 continuously -> grants in order 0,1,2,3,0; one write every 2 cycles.
- **Space gating:** free_count=2, req 1 len=3, req 3 len=1 -> no grant while free=2, req 3 not served first; after free_count rises to 3, req 1 granted and 3 words written.
- **Stall mid-burst:** owner drops req_valid for 2 cycles after word 1 of 4, another requester pending -> no writes and grant held during the gap; 4 words total then release; fifo_full high 1 cycle gives the same stall.
- **Reset mid-burst:** reset_n low after 2 of 5 words -> grant=0 and fifo_write=0 immediately; after release, requester 0 has priority.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NREQ burst requesters.
// A burst is granted whole, and only when the fifo's free space can hold all of its words.
module fifo_write_arbiter #(
    parameter int unsigned NREQ          = 4,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 12,
    parameter int unsigned LEN_WIDTH     = 4
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic [NREQ-1:0]              i_req_valid,
    input  logic [NREQ*LEN_WIDTH-1:0]    i_req_len,
    input  logic [NREQ*DATA_WIDTH-1:0]   i_req_data,
    output logic [NREQ-1:0]              o_req_ready,
    output logic [NREQ-1:0]              o_grant,
    output logic                         o_busy,
    output logic                         o_fifo_write,
    output logic [DATA_WIDTH-1:0]        o_fifo_write_data,
    input  logic                         i_fifo_full,
    input  logic [ADDRESS_WIDTH:0]       i_fifo_free_count
);

    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CntW = ADDRESS_WIDTH + 1;

    typedef enum logic [0:0] {
        StIdle,
        StBurst
    } state_e;

    state_e                r_state, w_state_next;
    logic [IdxW-1:0]       r_owner, w_owner_next;
    logic [IdxW-1:0]       r_last_owner, w_last_owner_next;
    logic [LEN_WIDTH-1:0]  r_remaining, w_remaining_next;
    logic [NREQ-1:0]       r_grant, w_grant_next;

    logic [NREQ-1:0]       w_eligible;
    logic [IdxW-1:0]       w_scan;
    logic                  w_cand_found;
    logic [IdxW-1:0]       w_cand;
    logic [LEN_WIDTH-1:0]  w_cand_len;
    logic                  w_cand_fits;
    logic                  w_in_burst;
    logic                  w_owner_valid;
    logic [DATA_WIDTH-1:0] w_owner_data;
    logic                  w_wr;

    function automatic logic [IdxW-1:0] wrap_idx(input logic [IdxW-1:0] base,
                                                 input int unsigned step);
        int unsigned sum;
        sum = 32'(base) + step;
        return IdxW'(sum % NREQ);
    endfunction

    always_comb begin
        w_eligible = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_eligible[i] = i_req_valid[i] && (i_req_len[i*LEN_WIDTH +: LEN_WIDTH] != '0);
        end
    end

    // Scan starts just after the last owner, so the last owner has lowest priority.
    always_comb begin
        w_cand_found = 1'b0;
        w_cand       = '0;
        w_scan       = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_scan = wrap_idx(r_last_owner, k);
            if (!w_cand_found && w_eligible[w_scan]) begin
                w_cand_found = 1'b1;
                w_cand       = w_scan;
            end
        end
    end

    assign w_cand_len    = i_req_len[w_cand*LEN_WIDTH +: LEN_WIDTH];
    assign w_cand_fits   = CntW'(w_cand_len) <= i_fifo_free_count;

    assign w_in_burst    = (r_state == StBurst);
    assign w_owner_valid = i_req_valid[r_owner];
    assign w_owner_data  = i_req_data[r_owner*DATA_WIDTH +: DATA_WIDTH];
    assign w_wr          = w_in_burst && w_owner_valid && !i_fifo_full;

    assign o_busy            = w_in_burst;
    assign o_grant           = r_grant;
    assign o_fifo_write      = w_wr;
    assign o_fifo_write_data = w_in_burst ? w_owner_data : '0;

    always_comb begin
        o_req_ready = '0;
        if (w_wr) begin
            o_req_ready[r_owner] = 1'b1;
        end
    end

    // A candidate that does not fit blocks arbitration rather than letting a smaller
    // burst overtake it; this keeps long bursts from starving.
    always_comb begin
        w_state_next      = r_state;
        w_owner_next      = r_owner;
        w_last_owner_next = r_last_owner;
        w_remaining_next  = r_remaining;
        w_grant_next      = r_grant;
        case (r_state)
            StIdle: begin
                if (w_cand_found && w_cand_fits) begin
                    w_state_next         = StBurst;
                    w_owner_next         = w_cand;
                    w_remaining_next     = w_cand_len;
                    w_grant_next         = '0;
                    w_grant_next[w_cand] = 1'b1;
                end
            end
            StBurst: begin
                if (w_wr) begin
                    w_remaining_next = r_remaining - LEN_WIDTH'(1);
                    if (r_remaining == LEN_WIDTH'(1)) begin
                        w_state_next      = StIdle;
                        w_last_owner_next = r_owner;
                        w_grant_next      = '0;
                    end
                end
            end
            default: begin
                w_state_next = StIdle;
                w_grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state      <= StIdle;
            r_owner      <= '0;
            r_last_owner <= IdxW'(NREQ - 1);
            r_remaining  <= '0;
            r_grant      <= '0;
        end else begin
            r_state      <= w_state_next;
            r_owner      <= w_owner_next;
            r_last_owner <= w_last_owner_next;
            r_remaining  <= w_remaining_next;
            r_grant      <= w_grant_next;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: per-cycle reference model check plus directed scenarios
// whose written-word sequences are compared against hand-computed lists.
module tb_fifo_write_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 12;
    localparam int unsigned LW   = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*LW-1:0]  req_len;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     grant;
    logic                busy;
    logic                fifo_write;
    logic [DW-1:0]       fifo_write_data;
    logic                fifo_full;
    logic [AW:0]         free_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Requester behaviour: burst of blen words base, base+1, ...
    bit act [NREQ];
    bit hold[NREQ];
    bit rep [NREQ];
    int blen[NREQ];
    int base[NREQ];
    int ptr [NREQ];
    logic [NREQ-1:0] s_ready = '0;

    // Log of words the DUT actually wrote, and the expected lists.
    int log_data[$];
    int log_src[$];
    int log_cyc[$];
    int exp_src[$];
    int exp_dat[$];

    // Reference model state.
    bit m_busy = 1'b0;
    int m_owner = 0;
    int m_rem = 0;
    int m_last = NREQ - 1;

    fifo_write_arbiter #(
        .NREQ         (NREQ),
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .LEN_WIDTH    (LW)
    ) dut (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .i_req_valid      (req_valid),
        .i_req_len        (req_len),
        .i_req_data       (req_data),
        .o_req_ready      (req_ready),
        .o_grant          (grant),
        .o_busy           (busy),
        .o_fifo_write     (fifo_write),
        .o_fifo_write_data(fifo_write_data),
        .i_fifo_full      (fifo_full),
        .i_fifo_free_count(free_cnt)
    );

    always #5 clk = ~clk;

    function automatic int len_of(int i);
        return int'(req_len[i*LW +: LW]);
    endfunction

    function automatic int onehot_idx(logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Rotating-priority pick: first requester after the last owner with a nonzero burst.
    function automatic int first_eligible(int last);
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (last + k) % NREQ;
            if (req_valid[c] && len_of(c) != 0) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int c;
        if (!rst_n) begin
            m_busy = 1'b0; m_owner = 0; m_rem = 0; m_last = NREQ - 1;
        end else if (!m_busy) begin
            c = first_eligible(m_last);
            if (c >= 0 && len_of(c) <= int'(free_cnt)) begin
                m_busy = 1'b1; m_owner = c; m_rem = len_of(c);
            end
        end else if (req_valid[m_owner] && !fifo_full) begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_busy = 1'b0; m_last = m_owner;
            end
        end
    end

    always @(negedge clk) begin
        logic [NREQ-1:0] eg, er;
        logic            ew;
        logic [DW-1:0]   ed;
        cyc++;
        s_ready = req_ready;
        eg = '0; er = '0; ew = 1'b0; ed = '0;
        if (m_busy) begin
            eg[m_owner] = 1'b1;
            ed = req_data[m_owner*DW +: DW];
            ew = req_valid[m_owner] && !fifo_full;
            if (ew) er[m_owner] = 1'b1;
        end
        n_checks++;
        if (grant !== eg || busy !== m_busy || fifo_write !== ew || req_ready !== er ||
            fifo_write_data !== ed) begin
            n_errors++;
            $display("FAIL model cyc=%0d got grant=%b busy=%b wr=%b ready=%b data=%h required grant=%b busy=%b wr=%b ready=%b data=%h",
                     cyc, grant, busy, fifo_write, req_ready, fifo_write_data,
                     eg, m_busy, ew, er, ed);
        end
        if (fifo_write === 1'b1) begin
            log_data.push_back(int'(fifo_write_data));
            log_src.push_back(onehot_idx(req_ready));
            log_cyc.push_back(cyc);
        end
    end

    task automatic chk(string name, logic [63:0] got, logic [63:0] req);
        n_checks++;
        if (got !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic chk_log(string name);
        chk({name, "_count"}, 64'(log_src.size()), 64'(exp_src.size()));
        for (int k = 0; k < exp_src.size() && k < log_src.size(); k++) begin
            chk($sformatf("%s_src%0d", name, k), 64'(log_src[k]), 64'(exp_src[k]));
            chk($sformatf("%s_dat%0d", name, k), 64'(log_data[k]), 64'(exp_dat[k]));
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]          = act[i] && !hold[i];
            req_len[i*LW +: LW]   = act[i] ? LW'(blen[i]) : '0;
            req_data[i*DW +: DW]  = DW'(base[i] + ptr[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (act[i] && s_ready[i]) begin
                ptr[i]++;
                if (ptr[i] >= blen[i]) begin
                    ptr[i] = 0;
                    if (!rep[i]) act[i] = 1'b0;
                end
            end
        end
        drive();
    endtask

    task automatic start(int i, int len, int b, bit r);
        act[i] = 1'b1; blen[i] = len; base[i] = b; ptr[i] = 0; rep[i] = r; hold[i] = 1'b0;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) begin
            act[i] = 1'b0; hold[i] = 1'b0; rep[i] = 1'b0; ptr[i] = 0; blen[i] = 0; base[i] = 0;
        end
    endtask

    task automatic clear_log();
        log_data.delete(); log_src.delete(); log_cyc.delete();
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        clear_reqs();
        drive();
        tick();
        tick();
        rst_n = 1'b1;
        clear_log();
    endtask

    task automatic wait_done(string name, int bound);
        int n;
        bit pending;
        n = 0;
        pending = 1'b1;
        while (pending && n < bound) begin
            pending = busy;
            for (int i = 0; i < NREQ; i++) if (act[i]) pending = 1'b1;
            if (pending) begin
                tick();
                n++;
            end
        end
        chk({name, "_done_in_budget"}, 64'(pending), 64'(0));
    endtask

    task automatic wait_ptr(string name, int i, int val, int bound);
        int n;
        n = 0;
        while (ptr[i] != val && n < bound) begin
            tick();
            n++;
        end
        chk({name, "_ptr_reached"}, 64'(ptr[i]), 64'(val));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        fifo_full = 1'b0;
        free_cnt  = 13'd4096;
        clear_reqs();
        drive();

        // Reset then idle
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 64'(grant), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_write", 64'(fifo_write), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(0));
        chk("rst_data", 64'(fifo_write_data), 64'(0));
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            #2;
            chk("idle_grant", 64'(grant), 64'(0));
            chk("idle_write", 64'(fifo_write), 64'(0));
        end

        // Single burst: requester 2, three words A0,A1,A2
        tick();
        clear_log();
        start(2, 3, 'hA0, 1'b0);
        drive();
        #2;
        chk("single_t_grant", 64'(grant), 64'(0));
        tick(); #2;
        chk("single_t1_grant", 64'(grant), 64'b0100);
        chk("single_t1_busy", 64'(busy), 64'(1));
        chk("single_t1_write", 64'(fifo_write), 64'(1));
        chk("single_t1_ready", 64'(req_ready), 64'b0100);
        chk("single_t1_data", 64'(fifo_write_data), 64'hA0);
        tick(); #2;
        chk("single_t2_data", 64'(fifo_write_data), 64'hA1);
        tick(); #2;
        chk("single_t3_data", 64'(fifo_write_data), 64'hA2);
        chk("single_t3_ready", 64'(req_ready), 64'b0100);
        tick(); #2;
        chk("single_t4_grant", 64'(grant), 64'(0));
        chk("single_t4_busy", 64'(busy), 64'(0));
        chk("single_t4_write", 64'(fifo_write), 64'(0));
        exp_src = '{2, 2, 2};
        exp_dat = '{'hA0, 'hA1, 'hA2};
        chk_log("single");

        // Round robin: all four requesting single words continuously
        reset_pulse();
        start(0, 1, 'h10, 1'b1);
        start(1, 1, 'h20, 1'b1);
        start(2, 1, 'h30, 1'b1);
        start(3, 1, 'h40, 1'b1);
        drive();
        repeat (10) tick();
        clear_reqs();
        drive();
        repeat (3) tick();
        exp_src = '{0, 1, 2, 3, 0};
        exp_dat = '{'h10, 'h20, 'h30, 'h40, 'h10};
        chk_log("rr");
        for (int k = 1; k < 5 && k < log_cyc.size(); k++) begin
            chk($sformatf("rr_spacing%0d", k), 64'(log_cyc[k] - log_cyc[k-1]), 64'(2));
        end

        // Space gating: requester 1 (len 3) blocks until three words fit; 3 not served first
        reset_pulse();
        free_cnt = 13'd2;
        start(1, 3, 'hB0, 1'b0);
        start(3, 1, 'hD0, 1'b0);
        drive();
        for (int k = 0; k < 5; k++) begin
            tick(); #2;
            chk("gate_grant", 64'(grant), 64'(0));
            chk("gate_write", 64'(fifo_write), 64'(0));
        end
        free_cnt = 13'd3;
        tick(); #2;
        chk("gate_grant_after", 64'(grant), 64'b0010);
        wait_done("gate", 20);
        exp_src = '{1, 1, 1, 3};
        exp_dat = '{'hB0, 'hB1, 'hB2, 'hD0};
        chk_log("gate");
        free_cnt = 13'd4096;

        // Stall: owner drops valid for two cycles after its first word
        reset_pulse();
        start(0, 4, 'h50, 1'b0);
        start(1, 2, 'h60, 1'b0);
        drive();
        wait_ptr("stall", 0, 1, 10);
        hold[0] = 1'b1;
        drive();
        #2;
        chk("stall1_write", 64'(fifo_write), 64'(0));
        chk("stall1_grant", 64'(grant), 64'b0001);
        tick(); #2;
        chk("stall2_write", 64'(fifo_write), 64'(0));
        chk("stall2_grant", 64'(grant), 64'b0001);
        hold[0] = 1'b0;
        tick(); #2;
        chk("stall_resume_data", 64'(fifo_write_data), 64'h51);
        wait_done("stall", 20);
        exp_src = '{0, 0, 0, 0, 1, 1};
        exp_dat = '{'h50, 'h51, 'h52, 'h53, 'h60, 'h61};
        chk_log("stall");

        // fifo_full high for one cycle mid-burst
        clear_log();
        start(2, 3, 'h70, 1'b0);
        drive();
        wait_ptr("full", 2, 1, 10);
        fifo_full = 1'b1;
        #2;
        chk("full_write", 64'(fifo_write), 64'(0));
        chk("full_ready", 64'(req_ready), 64'(0));
        chk("full_grant", 64'(grant), 64'b0100);
        tick();
        fifo_full = 1'b0;
        wait_done("full", 20);
        exp_src = '{2, 2, 2};
        exp_dat = '{'h70, 'h71, 'h72};
        chk_log("full");

        // Reset mid-burst: last owner 1 before reset, so only a reset puts 0 ahead of 2
        reset_pulse();
        start(1, 1, 'h80, 1'b0);
        drive();
        wait_done("pre", 10);
        start(2, 5, 'h90, 1'b0);
        drive();
        wait_ptr("midrst", 2, 2, 10);
        rst_n = 1'b0;
        clear_reqs();
        drive();
        #1;
        chk("midrst_grant", 64'(grant), 64'(0));
        chk("midrst_write", 64'(fifo_write), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        exp_src = '{1, 2, 2};
        exp_dat = '{'h80, 'h90, 'h91};
        chk_log("midrst");
        tick();
        tick();
        rst_n = 1'b1;
        clear_log();
        start(0, 1, 'hA8, 1'b0);
        start(2, 1, 'hC8, 1'b0);
        drive();
        wait_done("post", 20);
        exp_src = '{0, 2};
        exp_dat = '{'hA8, 'hC8};
        chk_log("postrst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
